// File: rtl/register_write_arbiter_pkg.sv
// write_arb_pkg: shared constants and helpers for register_write_arbiter.
// The optional stall counter (WRITE_ARB_STALL_COUNT_EN) uses STALL_COUNT_WIDTH.
package write_arb_pkg;

  localparam int STALL_COUNT_WIDTH = 16;

  // Widest packed per-requester bus and widest single field field_slice handles.
  localparam int FIELD_VEC_BITS = 256;
  localparam int FIELD_MAX_BITS = 32;

  // Extract field idx of width fw from a packed vector (field i at [i*fw +: fw]).
  function automatic logic [FIELD_MAX_BITS-1:0] field_slice(
    input logic [FIELD_VEC_BITS-1:0] vec,
    input int                        idx,
    input int                        fw
  );
    logic [FIELD_MAX_BITS-1:0] mask;
    mask = ~({FIELD_MAX_BITS{1'b1}} << fw);
    return FIELD_MAX_BITS'(vec >> (idx * fw)) & mask;
  endfunction

  // Pointer value after reset: the last requester, so requester 0 is searched first.
  function automatic int reset_ptr(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/register_write_arbiter_if.sv
// register_write_arbiter_if: requester-side write bus and register-bank strobes.
// master = requesters/bench, slave = the arbiter.
interface register_write_arbiter_if
  import write_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int WIDTH      = 8
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*WIDTH-1:0]      req_data;
  logic [NUM_REQ-1:0]            ack;
  logic [NUM_REGS-1:0]           write_enable;
  logic [WIDTH-1:0]              d;
  logic                          busy;

  modport master (
    output req, req_addr, req_data,
    input  ack, write_enable, d, busy
  );

  modport slave (
    input  req, req_addr, req_data,
    output ack, write_enable, d, busy
  );

endinterface

// File: rtl/register_write_arbiter_rr.sv
// round_robin_arbiter: masks requesters that are in their ack cycle, searches
// from the requester after the last one served, and remembers the winner.
module round_robin_arbiter
  import write_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  output logic [N-1:0] grant,
  output logic         valid
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] idx_k;
  logic [N-1:0]  eligible;

  // A requester still holding req during its own ack is not eligible again.
  assign eligible = req & ~mask;

  // Rotating search: first eligible requester at ptr+1, ptr+2, ... wrapping.
  always_comb begin
    grant     = '0;
    valid     = 1'b0;
    grant_idx = ptr;
    idx_k     = '0;
    for (int k = 1; k <= N; k++) begin
      idx_k = PW'((int'(ptr) + k) % N);
      if (!valid && eligible[idx_k]) begin
        valid            = 1'b1;
        grant_idx        = idx_k;
        grant[idx_k]     = 1'b1;
      end
    end
  end

  // Pointer follows the last grant; a grant made during reset is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= PW'(reset_ptr(N));
    end else if (valid) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/register_write_arbiter.sv
// register_write_arbiter: round-robin sharing of one register bank between
// NUM_REQ requesters. Grants are registered into one-cycle ack/write_enable
// pulses; out-of-range addresses are acked but never strobe a register.
// Optional: define WRITE_ARB_STALL_COUNT_EN to add the saturating stall_count output.
module register_write_arbiter
  import write_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int WIDTH      = 8
) (
  input logic                     clk,
  input logic                     reset,
  register_write_arbiter_if.slave bus
`ifdef WRITE_ARB_STALL_COUNT_EN
  ,
  output logic [STALL_COUNT_WIDTH-1:0] stall_count
`endif
);

  logic [NUM_REQ-1:0]    grant;
  logic                  grant_valid;
  int                    grant_num;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [WIDTH-1:0]      grant_data;
  logic [NUM_REGS-1:0]   we_next;

  logic [NUM_REQ-1:0]    ack_q;
  logic [NUM_REGS-1:0]   we_q;
  logic [WIDTH-1:0]      d_q;

  round_robin_arbiter #(.N(NUM_REQ)) u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (bus.req),
    .mask  (ack_q),
    .grant (grant),
    .valid (grant_valid)
  );

  // Turn the one-hot grant into an index and pick that requester's fields.
  always_comb begin
    grant_num = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_num = i;
    end
    grant_addr = ADDR_WIDTH'(field_slice(FIELD_VEC_BITS'(bus.req_addr), grant_num, ADDR_WIDTH));
    grant_data = WIDTH'(field_slice(FIELD_VEC_BITS'(bus.req_data), grant_num, WIDTH));
  end

  // Address decode; addresses at or beyond NUM_REGS match no strobe.
  always_comb begin
    we_next = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (grant_valid && (int'(grant_addr) == r)) we_next[r] = 1'b1;
    end
  end

  // Output registers: strobes last one cycle, d keeps the last written value.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q <= '0;
      we_q  <= '0;
      d_q   <= '0;
    end else begin
      ack_q <= grant;
      we_q  <= we_next;
      if (grant_valid) d_q <= grant_data;
    end
  end

  assign bus.ack          = ack_q;
  assign bus.write_enable = we_q;
  assign bus.d            = d_q;
  assign bus.busy         = (|ack_q) | (|we_q);

`ifdef WRITE_ARB_STALL_COUNT_EN
  logic [NUM_REQ-1:0] stalled;

  assign stalled = bus.req & ~ack_q & ~grant;

  // Count cycles where some eligible requester lost arbitration; saturate.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
    end else if ((|stalled) && (stall_count != {STALL_COUNT_WIDTH{1'b1}})) begin
      stall_count <= stall_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_register_write_arbiter.sv
// tb_register_write_arbiter: directed vector table followed by randomized
// requester traffic checked against a behavioural round-robin model.
module tb_register_write_arbiter;

  localparam int NUM_REQ    = 2;
  localparam int NUM_REGS   = 12;
  localparam int ADDR_WIDTH = 4;
  localparam int WIDTH      = 8;

  logic clk;
  logic reset;

  register_write_arbiter_if #(
    .NUM_REQ(NUM_REQ), .NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH), .WIDTH(WIDTH)
  ) bus ();

`ifdef WRITE_ARB_STALL_COUNT_EN
  logic [15:0] stall_count;
`endif

  register_write_arbiter #(
    .NUM_REQ(NUM_REQ), .NUM_REGS(NUM_REGS), .ADDR_WIDTH(ADDR_WIDTH), .WIDTH(WIDTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef WRITE_ARB_STALL_COUNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank driven by the DUT strobes.
  logic [WIDTH-1:0] bank [NUM_REGS];
  always @(posedge clk) begin
    for (int r = 0; r < NUM_REGS; r++)
      if (bus.write_enable[r]) bank[r] <= bus.d;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: pointer and who is currently being acked.
  int               m_ptr;
  int               m_ack_idx;
  logic [NUM_REGS-1:0] m_we;
  logic [WIDTH-1:0] m_d;
  int               m_stall;
  logic [WIDTH-1:0] m_bank [NUM_REGS];

  task automatic model_step();
    int g, nelig, i, a;
    g = -1;
    nelig = 0;
    if (reset) begin
      m_ptr     = NUM_REQ - 1;
      m_ack_idx = -1;
      m_we      = '0;
      m_d       = '0;
      m_stall   = 0;
      return;
    end
    for (int k = 1; k <= NUM_REQ; k++) begin
      i = (m_ptr + k) % NUM_REQ;
      if (bus.req[i] && i != m_ack_idx) begin
        nelig++;
        if (g < 0) g = i;
      end
    end
    if (nelig > 1 && m_stall < 65535) m_stall++;
    m_we = '0;
    if (g >= 0) begin
      a = int'(bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH]);
      m_d = bus.req_data[g*WIDTH +: WIDTH];
      if (a < NUM_REGS) begin
        m_we[a] = 1'b1;
        m_bank[a] = m_d;
      end
      m_ptr = g;
      m_ack_idx = g;
    end else begin
      m_ack_idx = -1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  req;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [1:0]  ack;
    logic [11:0] we;
    logic [7:0]  d;
  } vec_t;

  vec_t tbl [23];
  logic [7:0] exp_bank [NUM_REGS];

  initial begin
    logic [NUM_REQ-1:0] nreq;
    logic [NUM_REQ*ADDR_WIDTH-1:0] naddr;
    logic [NUM_REQ*WIDTH-1:0] ndata;
    logic [NUM_REQ-1:0] just_acked;
    logic [NUM_REQ-1:0] exp_ack;

    for (int r = 0; r < NUM_REGS; r++) begin
      bank[r] = '0;
      m_bank[r] = '0;
      exp_bank[r] = '0;
    end
    exp_bank[1] = 8'h11; exp_bank[2] = 8'h22; exp_bank[3] = 8'hA5;
    exp_bank[4] = 8'h99; exp_bank[5] = 8'h3C;
    m_ptr = NUM_REQ - 1; m_ack_idx = -1; m_we = '0; m_d = '0; m_stall = 0;

    //            rst   req    addr   data      ack    we       d
    tbl[0]  = '{1'b1, 2'b00, 8'h00, 16'h0000, 2'b00, 12'h000, 8'h00};
    tbl[1]  = '{1'b0, 2'b01, 8'h03, 16'h00A5, 2'b01, 12'h008, 8'hA5};
    tbl[2]  = '{1'b0, 2'b01, 8'h03, 16'h00A5, 2'b00, 12'h000, 8'hA5};
    tbl[3]  = '{1'b0, 2'b00, 8'h00, 16'h0000, 2'b00, 12'h000, 8'hA5};
    tbl[4]  = '{1'b1, 2'b00, 8'h00, 16'h0000, 2'b00, 12'h000, 8'h00};
    tbl[5]  = '{1'b0, 2'b11, 8'h21, 16'h2211, 2'b01, 12'h002, 8'h11};
    tbl[6]  = '{1'b0, 2'b11, 8'h21, 16'h2211, 2'b10, 12'h004, 8'h22};
    tbl[7]  = '{1'b0, 2'b11, 8'h21, 16'h2211, 2'b01, 12'h002, 8'h11};
    tbl[8]  = '{1'b0, 2'b11, 8'h21, 16'h2211, 2'b10, 12'h004, 8'h22};
    tbl[9]  = '{1'b0, 2'b10, 8'h21, 16'h2211, 2'b00, 12'h000, 8'h22};
    tbl[10] = '{1'b0, 2'b00, 8'h00, 16'h0000, 2'b00, 12'h000, 8'h22};
    tbl[11] = '{1'b0, 2'b10, 8'h50, 16'h3C00, 2'b10, 12'h020, 8'h3C};
    tbl[12] = '{1'b0, 2'b10, 8'h50, 16'h3C00, 2'b00, 12'h000, 8'h3C};
    tbl[13] = '{1'b0, 2'b10, 8'h50, 16'h3C00, 2'b10, 12'h020, 8'h3C};
    tbl[14] = '{1'b0, 2'b10, 8'h50, 16'h3C00, 2'b00, 12'h000, 8'h3C};
    tbl[15] = '{1'b0, 2'b00, 8'h00, 16'h0000, 2'b00, 12'h000, 8'h3C};
    tbl[16] = '{1'b0, 2'b01, 8'h0F, 16'h0077, 2'b01, 12'h000, 8'h77};
    tbl[17] = '{1'b0, 2'b01, 8'h0F, 16'h0077, 2'b00, 12'h000, 8'h77};
    tbl[18] = '{1'b0, 2'b00, 8'h00, 16'h0000, 2'b00, 12'h000, 8'h77};
    tbl[19] = '{1'b1, 2'b01, 8'h04, 16'h0099, 2'b00, 12'h000, 8'h00};
    tbl[20] = '{1'b0, 2'b01, 8'h04, 16'h0099, 2'b01, 12'h010, 8'h99};
    tbl[21] = '{1'b0, 2'b01, 8'h04, 16'h0099, 2'b00, 12'h000, 8'h99};
    tbl[22] = '{1'b0, 2'b00, 8'h00, 16'h0000, 2'b00, 12'h000, 8'h99};

    reset = 1'b1; bus.req = '0; bus.req_addr = '0; bus.req_data = '0;

    for (int v = 0; v < 23; v++) begin
      reset        = tbl[v].rst;
      bus.req      = tbl[v].req;
      bus.req_addr = tbl[v].addr;
      bus.req_data = tbl[v].data;
      tick();
      check($sformatf("vec%0d_ack", v),  bus.ack,          tbl[v].ack);
      check($sformatf("vec%0d_we", v),   bus.write_enable, tbl[v].we);
      check($sformatf("vec%0d_d", v),    bus.d,            tbl[v].d);
      check($sformatf("vec%0d_busy", v), bus.busy,         (tbl[v].ack != 2'b00));
    end
    tick();
    for (int r = 0; r < NUM_REGS; r++)
      check($sformatf("bank_directed_r%0d", r), bank[r], exp_bank[r]);

    // Randomized traffic obeying the requester hold/withdraw rules.
    just_acked = '0;
    for (int c = 0; c < 3000; c++) begin
      nreq = bus.req; naddr = bus.req_addr; ndata = bus.req_data;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.ack[i]) begin
          // hold through the ack cycle
        end else if (!bus.req[i] || just_acked[i]) begin
          nreq[i] = ($urandom_range(0, 3) != 0);
          naddr[i*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'($urandom_range(0, 15));
          ndata[i*WIDTH +: WIDTH] = WIDTH'($urandom);
        end else if ($urandom_range(0, 15) == 0) begin
          nreq[i] = 1'b0;
        end
      end
      just_acked   = bus.ack;
      reset        = ($urandom_range(0, 63) == 0);
      bus.req      = nreq;
      bus.req_addr = naddr;
      bus.req_data = ndata;
      tick();
      exp_ack = '0;
      if (m_ack_idx >= 0) exp_ack[m_ack_idx] = 1'b1;
      check($sformatf("rnd%0d_ack", c),  bus.ack,          exp_ack);
      check($sformatf("rnd%0d_we", c),   bus.write_enable, m_we);
      check($sformatf("rnd%0d_d", c),    bus.d,            m_d);
      check($sformatf("rnd%0d_busy", c), bus.busy,         (m_ack_idx >= 0));
`ifdef WRITE_ARB_STALL_COUNT_EN
      check($sformatf("rnd%0d_stall", c), stall_count, m_stall);
`endif
    end

    reset = 1'b0; bus.req = '0;
    tick();
    tick();
    tick();
    for (int r = 0; r < NUM_REGS; r++)
      check($sformatf("bank_random_r%0d", r), bank[r], m_bank[r]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
